// File: rtl/fetch_pkg.sv
// Shared constants and the fetch-queue entry type for the instruction fetch slice.
package fetch_pkg;

  localparam int          DATA_WIDTH_DEF  = 32;
  localparam int          ADDR_WIDTH_DEF  = 32;
  localparam int          FETCH_DEPTH_DEF = 2;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP         = 32'd4;
  localparam logic [31:0] INSTR_NOP       = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] pc;
    logic [DATA_WIDTH_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port plus the {pc, instr} valid/ready channel toward IF/ID.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Small registered FIFO holding fetched {pc, instr} words; flush wins over push and pop.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// PC sequencing, redirect/flush and halt control around a fetch_queue.
// Optional FETCH_PERF_CNT_EN adds fetch and stall event counters.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DEPTH      = FETCH_DEPTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_if.master               bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ENTRY_W-1:0]    head_data;
  logic [CNT_W-1:0]      q_count;
  logic                  q_full;
  logic                  q_empty;
  logic                  pop;
  logic                  can_push;
  logic                  fetch;

  assign pop      = bus.out_valid & bus.out_ready;
  assign can_push = ~q_full | pop;
  assign fetch    = fetch_en & can_push & ~redirect_valid;

  assign bus.imem_addr = {2'b00, pc_reg[ADDR_WIDTH-1:2]};
  assign bus.out_valid = (q_count != '0);
  assign bus.out_pc    = q_empty ? '0 : head_data[ENTRY_W-1:DATA_WIDTH];
  assign bus.out_instr = q_empty ? DATA_WIDTH'(INSTR_NOP) : head_data[DATA_WIDTH-1:0];

  // A redirect flushes the queue, so the pop it coincides with is dropped.
  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fetch),
    .push_data ({pc_reg, bus.imem_instr}),
    .pop       (pop & ~redirect_valid),
    .head_data (head_data),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (redirect_valid) begin
      pc_reg <= redirect_pc & ~ADDR_WIDTH'(3);
    end else if (fetch) begin
      pc_reg <= pc_reg + ADDR_WIDTH'(PC_STEP);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (fetch_en && !can_push && !redirect_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
